// File: rtl/nvram_pkg.sv
// Shared types and constants for the NVRAM upload bridge.
package nvram_pkg;

  typedef enum logic [0:0] {NV_IDLE, NV_FETCH} nv_state_t;

  localparam logic [7:0] NV_INDEX_DEFAULT = 8'd4;
  localparam logic [7:0] NV_PAD           = 8'hFF;

endpackage

// File: rtl/nvram_upload_bridge_if.sv
// hps_io ioctl upload channel: master is hps_io, slave is the NVRAM bridge.
interface nvram_upload_bridge_if;

  logic        ioctl_upload;
  logic [7:0]  ioctl_index;
  logic        ioctl_rd;
  logic [16:0] ioctl_addr;
  logic [7:0]  ioctl_din;
  logic        ioctl_wait;
  logic        ioctl_upload_req;

  modport master (
    output ioctl_upload, ioctl_index, ioctl_rd, ioctl_addr,
    input  ioctl_din, ioctl_wait, ioctl_upload_req
  );

  modport slave (
    input  ioctl_upload, ioctl_index, ioctl_rd, ioctl_addr,
    output ioctl_din, ioctl_wait, ioctl_upload_req
  );

endinterface

// File: rtl/nvram_autosave_timer.sv
// Tracks CPU CMOS writes and requests an NVRAM upload after SAVE_TICKS quiet cycles.
// Only instantiated when NVRAM_AUTOSAVE_EN is defined.
module nvram_autosave_timer #(
  parameter int unsigned SAVE_TICKS = 24_000_000
) (
  input  logic clk_sys,
  input  logic reset_n,
  input  logic active,
  input  logic cpu_nv_we,
  output logic upload_req
);

  localparam int unsigned     TMR_W = $clog2(SAVE_TICKS + 1);
  localparam logic [TMR_W-1:0] TICKS = TMR_W'(SAVE_TICKS);

  logic             active_q;
  logic             dirty, dirty_n;
  logic [TMR_W-1:0] timer, timer_n;
  logic             req_n;
  logic             start_c;

  assign start_c = active & ~active_q;

  // A CPU write in the same cycle an upload starts keeps the data marked dirty.
  always_comb begin
    dirty_n = dirty;
    timer_n = timer;
    req_n   = upload_req;
    if (cpu_nv_we) begin
      dirty_n = 1'b1;
      timer_n = '0;
    end else if (start_c) begin
      dirty_n = 1'b0;
      timer_n = '0;
    end else if (dirty && !active && timer != TICKS) begin
      timer_n = timer + TMR_W'(1);
    end
    if (start_c) begin
      req_n = 1'b0;
    end else if (dirty_n && timer_n == TICKS) begin
      req_n = 1'b1;
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      active_q   <= 1'b0;
      dirty      <= 1'b0;
      timer      <= '0;
      upload_req <= 1'b0;
    end else begin
      active_q   <= active;
      dirty      <= dirty_n;
      timer      <= timer_n;
      upload_req <= req_n;
    end
  end

endmodule

// File: rtl/nvram_upload_bridge.sv
// Serves CMOS/NVRAM contents to hps_io uploads through the CMOS RAM's second read port.
// Define NVRAM_AUTOSAVE_EN to raise ioctl_upload_req after the CPU modifies CMOS.
module nvram_upload_bridge
  import nvram_pkg::*;
#(
  parameter int unsigned ADDR_W     = 10,
  parameter int unsigned DATA_W     = 4,
  parameter logic [7:0]  NV_INDEX   = NV_INDEX_DEFAULT,
  parameter int unsigned RD_LAT     = 1,
  parameter int unsigned SAVE_TICKS = 24_000_000
) (
  input  logic                clk_sys,
  input  logic                reset_n,
  nvram_upload_bridge_if.slave ioctl,
  output logic [ADDR_W-1:0]   nv_addr,
  output logic                nv_rd,
  input  logic [DATA_W-1:0]   nv_rdata,
  input  logic                cpu_nv_we
);

  localparam int unsigned LAT_W = 2;

  nv_state_t         state, state_n;
  logic [LAT_W-1:0]  lat_cnt, lat_cnt_n;
  logic [7:0]        din_q, din_n;
  logic              wait_q, wait_n;
  logic [ADDR_W-1:0] nv_addr_n;
  logic              nv_rd_n;
  logic              active_c;
  logic              in_range_c;
  logic              upload_req;

  assign active_c   = ioctl.ioctl_upload & (ioctl.ioctl_index == NV_INDEX);
  assign in_range_c = (ioctl.ioctl_addr >> ADDR_W) == 17'd0;

  // Fetch sequencing; read strobes arriving mid-fetch are dropped.
  always_comb begin
    state_n   = state;
    lat_cnt_n = lat_cnt;
    din_n     = din_q;
    wait_n    = wait_q;
    nv_addr_n = nv_addr;
    nv_rd_n   = 1'b0;
    unique case (state)
      NV_IDLE: begin
        if (active_c && ioctl.ioctl_rd) begin
          if (in_range_c) begin
            state_n   = NV_FETCH;
            nv_addr_n = ioctl.ioctl_addr[ADDR_W-1:0];
            nv_rd_n   = 1'b1;
            wait_n    = 1'b1;
            lat_cnt_n = '0;
          end else begin
            din_n = NV_PAD;
          end
        end
      end
      NV_FETCH: begin
        if (!active_c) begin
          state_n = NV_IDLE;
          wait_n  = 1'b0;
        end else if (lat_cnt == LAT_W'(RD_LAT)) begin
          state_n = NV_IDLE;
          din_n   = 8'(nv_rdata);
          wait_n  = 1'b0;
        end else begin
          lat_cnt_n = lat_cnt + LAT_W'(1);
        end
      end
      default: state_n = NV_IDLE;
    endcase
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state   <= NV_IDLE;
      lat_cnt <= '0;
      din_q   <= 8'h00;
      wait_q  <= 1'b0;
      nv_addr <= '0;
      nv_rd   <= 1'b0;
    end else begin
      state   <= state_n;
      lat_cnt <= lat_cnt_n;
      din_q   <= din_n;
      wait_q  <= wait_n;
      nv_addr <= nv_addr_n;
      nv_rd   <= nv_rd_n;
    end
  end

`ifdef NVRAM_AUTOSAVE_EN
  nvram_autosave_timer #(
    .SAVE_TICKS (SAVE_TICKS)
  ) u_autosave (
    .clk_sys    (clk_sys),
    .reset_n    (reset_n),
    .active     (active_c),
    .cpu_nv_we  (cpu_nv_we),
    .upload_req (upload_req)
  );
`else
  logic unused_autosave;
  assign unused_autosave = cpu_nv_we | (SAVE_TICKS == 0);
  assign upload_req      = 1'b0;
`endif

  assign ioctl.ioctl_din        = din_q;
  assign ioctl.ioctl_wait       = wait_q;
  assign ioctl.ioctl_upload_req = upload_req;

endmodule

// File: tb/tb_nvram_upload_bridge.sv
// Randomized self-checking bench for nvram_upload_bridge (RD_LAT=1 and RD_LAT=3 instances).
module tb_nvram_upload_bridge;

  logic        clk_sys = 1'b0;
  logic        reset_n = 1'b0;
  logic        upload  = 1'b0;
  logic [7:0]  index   = 8'd0;
  logic        rd      = 1'b0;
  logic [16:0] addr    = '0;
  logic        cpu_nv_we = 1'b0;

  logic [9:0]  nv_addr1, nv_addr3;
  logic        nv_rd1, nv_rd3;
  logic [3:0]  rdata1, p3_0, p3_1, rdata3;
  logic [3:0]  mem [1024];

  logic [7:0]  din_m = 8'h00;
  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk_sys = ~clk_sys;

  nvram_upload_bridge_if bus1 ();
  nvram_upload_bridge_if bus3 ();

  assign bus1.ioctl_upload = upload;
  assign bus1.ioctl_index  = index;
  assign bus1.ioctl_rd     = rd;
  assign bus1.ioctl_addr   = addr;
  assign bus3.ioctl_upload = upload;
  assign bus3.ioctl_index  = index;
  assign bus3.ioctl_rd     = rd;
  assign bus3.ioctl_addr   = addr;

  nvram_upload_bridge #(.RD_LAT(1), .SAVE_TICKS(16)) u_dut1 (
    .clk_sys(clk_sys), .reset_n(reset_n), .ioctl(bus1),
    .nv_addr(nv_addr1), .nv_rd(nv_rd1), .nv_rdata(rdata1), .cpu_nv_we(cpu_nv_we)
  );

  nvram_upload_bridge #(.RD_LAT(3), .SAVE_TICKS(16)) u_dut3 (
    .clk_sys(clk_sys), .reset_n(reset_n), .ioctl(bus3),
    .nv_addr(nv_addr3), .nv_rd(nv_rd3), .nv_rdata(rdata3), .cpu_nv_we(cpu_nv_we)
  );

  // CMOS read ports: data valid 1 and 3 cycles after the strobe respectively
  always @(posedge clk_sys) begin
    if (nv_rd1) rdata1 <= mem[nv_addr1];
    if (nv_rd3) p3_0 <= mem[nv_addr3];
    p3_1   <= p3_0;
    rdata3 <= p3_1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // One upload read; called at a negedge, returns at a negedge with both instances idle.
  task automatic do_read(input logic [16:0] a);
    bit         act, inr;
    logic [7:0] exp, first1, first3;
    int         np1, np3, nw1, nw3;
    logic [9:0] na1, na3;
    np1 = 0; np3 = 0; nw1 = 0; nw3 = 0; na1 = '0; na3 = '0;
    act = upload && (index == 8'd4);
    inr = (a < 17'd1024);
    exp = !act ? din_m : (inr ? {4'h0, mem[a[9:0]]} : 8'hFF);
    rd = 1'b1; addr = a;
    @(negedge clk_sys);
    rd = 1'b0; addr = 17'($urandom);
    first1 = bus1.ioctl_din;
    first3 = bus3.ioctl_din;
    for (int c = 0; c < 7; c++) begin
      if (nv_rd1) begin np1++; na1 = nv_addr1; end
      if (nv_rd3) begin np3++; na3 = nv_addr3; end
      if (bus1.ioctl_wait) nw1++;
      if (bus3.ioctl_wait) nw3++;
      @(negedge clk_sys);
    end
    din_m = exp;
    check("nv_rd_count_lat1", np1, (act && inr) ? 1 : 0);
    check("nv_rd_count_lat3", np3, (act && inr) ? 1 : 0);
    if (act && inr) begin
      check("nv_addr_lat1", na1, a[9:0]);
      check("nv_addr_lat3", na3, a[9:0]);
    end
    check("wait_cycles_lat1", nw1, (act && inr) ? 2 : 0);
    check("wait_cycles_lat3", nw3, (act && inr) ? 4 : 0);
    check("din_lat1", bus1.ioctl_din, exp);
    check("din_lat3", bus3.ioctl_din, exp);
    if (act && !inr) begin
      check("pad_next_cycle_lat1", first1, 8'hFF);
      check("pad_next_cycle_lat3", first3, 8'hFF);
    end
  endtask

  // Cycles from a cpu_nv_we sample to upload_req high (0 = never within window).
  task automatic autosave_run(input bit second_pulse, output int first);
    first = 0;
    @(negedge clk_sys); cpu_nv_we = 1'b1;
    @(negedge clk_sys); cpu_nv_we = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk_sys);
      if (bus1.ioctl_upload_req && first == 0) first = k;
      if (second_pulse && k == 9)  cpu_nv_we = 1'b1;
      if (second_pulse && k == 10) cpu_nv_we = 1'b0;
    end
  endtask

  initial begin
    int np, first;
`ifdef NVRAM_AUTOSAVE_EN
    int exp_a = 16, exp_b = 26;
`else
    int exp_a = 0, exp_b = 0;
`endif

    for (int i = 0; i < 1024; i++) mem[i] = 4'($urandom);
    #23;
    check("rst_din", bus1.ioctl_din, 8'h00);
    check("rst_wait", bus1.ioctl_wait, 1'b0);
    check("rst_req", bus1.ioctl_upload_req, 1'b0);
    check("rst_nv_rd", nv_rd1, 1'b0);
    check("rst_nv_addr", nv_addr1, 10'd0);
    @(negedge clk_sys); reset_n = 1'b1;
    @(negedge clk_sys);

    // basic fetch
    mem[5] = 4'hA; upload = 1'b1; index = 8'd4;
    do_read(17'd5);
    check("basic_din", bus1.ioctl_din, 8'h0A);
    // wrong index: ignored
    mem[5] = 4'h3; index = 8'd0;
    do_read(17'd5);
    // out of range
    index = 8'd4;
    do_read(17'h00400);
    do_read(17'h1FFFF);

    // full address sweep
    for (int i = 0; i < 1024; i++) mem[i] = 4'(i);
    for (int i = 0; i < 1024; i++) do_read(17'(i));

    // randomized mix
    for (int i = 0; i < 1024; i++) mem[i] = 4'($urandom);
    for (int n = 0; n < 300; n++) begin
      upload = ($urandom_range(0, 9) != 0);
      index  = ($urandom_range(0, 9) != 0) ? 8'd4 : 8'($urandom_range(0, 255));
      if ($urandom_range(0, 4) == 0) do_read(17'($urandom_range(1024, 131071)));
      else                           do_read(17'($urandom_range(0, 1023)));
    end

    // upload dropped mid-fetch
    upload = 1'b1; index = 8'd4;
    mem[7] = ~din_m[3:0];
    rd = 1'b1; addr = 17'd7;
    @(negedge clk_sys); rd = 1'b0;
    check("abort_wait_pre", bus1.ioctl_wait, 1'b1);
    upload = 1'b0;
    @(negedge clk_sys);
    check("abort_wait_lat1", bus1.ioctl_wait, 1'b0);
    check("abort_wait_lat3", bus3.ioctl_wait, 1'b0);
    np = 0;
    for (int c = 0; c < 6; c++) begin
      np += int'(nv_rd1) + int'(nv_rd3);
      @(negedge clk_sys);
    end
    check("abort_no_nv_rd", np, 0);
    check("abort_din_lat1", bus1.ioctl_din, din_m);
    check("abort_din_lat3", bus3.ioctl_din, din_m);
    upload = 1'b1;
    do_read(17'd7);

    // async reset while the read strobe is out
    mem[9] = 4'hC;
    rd = 1'b1; addr = 17'd9;
    @(negedge clk_sys); rd = 1'b0;
    #1 reset_n = 1'b0;
    #1;
    check("rst_mid_wait", bus3.ioctl_wait, 1'b0);
    check("rst_mid_nv_rd", nv_rd1, 1'b0);
    check("rst_mid_din", bus1.ioctl_din, 8'h00);
    check("rst_mid_nv_addr", nv_addr1, 10'd0);
    @(negedge clk_sys); reset_n = 1'b1;
    din_m = 8'h00;
    np = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk_sys);
      np += int'(nv_rd1) + int'(nv_rd3);
    end
    check("rst_no_nv_rd", np, 0);
    do_read(17'd9);

    // autosave request timing
    upload = 1'b0;
    @(negedge clk_sys);
    autosave_run(1'b0, first);
    check("autosave_single", first, exp_a);
    check("autosave_req_held", bus3.ioctl_upload_req, (exp_a != 0) ? 1 : 0);
    upload = 1'b1; index = 8'd4;
    @(negedge clk_sys);
    check("autosave_clear_lat1", bus1.ioctl_upload_req, 1'b0);
    check("autosave_clear_lat3", bus3.ioctl_upload_req, 1'b0);
    upload = 1'b0;
    autosave_run(1'b1, first);
    check("autosave_retrigger", first, exp_b);
    upload = 1'b1;
    @(negedge clk_sys);
    check("autosave_clear2", bus1.ioctl_upload_req, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
